// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 8-bit accumulator CPU.
// Owns the shared von Neumann memory port, gates control-unit enables into strobes, times out stalls.
module fetch_exec_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [2:0]       opcode,
  input  logic             ctl_regWE,
  input  logic             ctl_memWE,
  input  logic             ctl_accWE,
  input  logic             ctl_brnch,
  input  logic             ctl_selMemIn,
  input  logic             alu_nz,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             reg_we,
  output logic             mem_we,
  output logic             acc_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int WC_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic in_access;
  logic timeout;
  logic complete;
  logic mem_req_c, mem_sel_c, ir_we_c, pc_we_c, pc_sel_branch_c;
  logic reg_we_c, mem_we_c, acc_we_c;

  // opcode is informational only; the control unit has already decoded it into ctl_*.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  // Memory handshake: mem_req is held for the whole access; the access completes in the
  // cycle where mem_req=1 and mem_ready=1, and any strobe tied to it fires in that same cycle.
  always_comb begin
    in_access = (state_q == S_FETCH) || (state_q == S_MEM);
    timeout   = (WAIT_MAX != 0) && in_access && !mem_ready && (wait_cnt_q == WAIT_LIM);
  end

  always_comb begin
    state_d         = state_q;
    complete        = 1'b0;
    mem_req_c       = 1'b0;
    mem_sel_c       = 1'b0;
    ir_we_c         = 1'b0;
    pc_we_c         = 1'b0;
    pc_sel_branch_c = 1'b0;
    reg_we_c        = 1'b0;
    mem_we_c        = 1'b0;
    acc_we_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        // Strobe-free cycle so the control unit settles on the freshly loaded IR.
        state_d = ctl_selMemIn ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        reg_we_c        = ctl_regWE;
        acc_we_c        = ctl_accWE;
        pc_we_c         = 1'b1;
        pc_sel_branch_c = ctl_brnch & alu_nz;
        complete        = 1'b1;
        state_d         = halt_req ? S_IDLE : S_FETCH;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_sel_c = 1'b1;
        if (mem_ready) begin
          mem_we_c = ctl_memWE;
          reg_we_c = ctl_regWE;
          pc_we_c  = 1'b1;
          complete = 1'b1;
          state_d  = halt_req ? S_IDLE : S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_cnt_d = '0;
    end else if (in_access && !mem_ready && (wait_cnt_q != WAIT_LIM)) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (complete) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  // Reset landing mid-access must not let a completion strobe escape in that cycle.
  assign mem_req       = mem_req_c       & ~reset;
  assign mem_sel       = mem_sel_c       & ~reset;
  assign ir_we         = ir_we_c         & ~reset;
  assign pc_we         = pc_we_c         & ~reset;
  assign pc_sel_branch = pc_sel_branch_c & ~reset;
  assign reg_we        = reg_we_c        & ~reset;
  assign mem_we        = mem_we_c        & ~reset;
  assign acc_we        = acc_we_c        & ~reset;

  assign busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault   = (state_q == S_FAULT);
  assign state   = state_q;
  assign retired = retired_q;

endmodule
